// File: rtl/fx68k_pkg.sv
// Shared types for the fx68k bus arbiter: arbitration states and the
// registered pin-level output bundle decoded from them.
package fx68k_pkg;

    localparam int ARB_SYNC_MAX  = 3;
    localparam int ARB_RECLAIM_W = 3;

    typedef enum logic [2:0] {
        ARB_OWN,
        ARB_PEND,
        ARB_GRANT,
        ARB_EXT,
        ARB_RECLAIM
    } e_arbState;

    typedef struct packed {
        logic bg_n;
        logic cpu_owns_bus;
        logic bus_idle;
    } arb_out_t;

    function automatic arb_out_t arb_outputs(input e_arbState s);
        arb_out_t o;
        o.bg_n         = (s != ARB_GRANT);
        o.cpu_owns_bus = (s == ARB_OWN) || (s == ARB_PEND);
        o.bus_idle     = (s == ARB_EXT) || (s == ARB_RECLAIM);
        return o;
    endfunction

endpackage

// File: rtl/fx68k_sync_ce.sv
// Enable-qualified multi-stage synchronizer for active-low asynchronous pins;
// every stage resets to 1 so the pin reads as negated out of reset.
module fx68k_sync_ce #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_i,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES:0]   shift;

    // Appending the input and dropping the top bit keeps STAGES=1 legal.
    assign shift = {sync_q, d_i};

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            sync_q <= '1;
        end else if (en_i) begin
            sync_q <= shift[STAGES-1:0];
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fx68k_bus_arbiter.sv
// 68000 BR/BG/BGACK arbitration for the fx68k core: hands the bus to an
// external master only between bus cycles and never inside a locked TAS.
module fx68k_bus_arbiter
    import fx68k_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RECLAIM_PHI = 1
) (
    input  logic clk,
    input  logic extReset,
    input  logic enPhi1,
    input  logic enPhi2,
    input  logic BRn,
    input  logic BGACKn,
    input  logic busActive,
    input  logic busEnd,
    input  logic isRmc,
    output logic BGn,
    output logic cpuOwnsBus,
    output logic busIdle
);

    localparam int SYNC_N = (SYNC_STAGES > ARB_SYNC_MAX) ? ARB_SYNC_MAX :
                            ((SYNC_STAGES < 1) ? 1 : SYNC_STAGES);

    logic br_sync;
    logic ack_sync;
    logic br_req;
    logic ack_act;
    logic grant_ok;

    e_arbState                state_q,        state_d;
    logic [ARB_RECLAIM_W-1:0] reclaim_q,      reclaim_d;
    logic                     bus_end_seen_q, bus_end_seen_d;
    arb_out_t                 out_q,          out_d;

    fx68k_sync_ce #(.STAGES(SYNC_N)) u_br_sync (
        .clk   (clk),
        .rst_i (extReset),
        .en_i  (enPhi2),
        .d_i   (BRn),
        .q_o   (br_sync)
    );

    fx68k_sync_ce #(.STAGES(SYNC_N)) u_ack_sync (
        .clk   (clk),
        .rst_i (extReset),
        .en_i  (enPhi2),
        .d_i   (BGACKn),
        .q_o   (ack_sync)
    );

    assign br_req  = ~br_sync;
    assign ack_act = ~ack_sync;

    // The bus may change hands once no cycle is running or the running one
    // ended on the last enPhi2, and never while a locked RMW is open.
    assign grant_ok = ~isRmc & (~busActive | bus_end_seen_q);

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (enPhi1) begin
            case (state_q)
                ARB_OWN: begin
                    // An idle bus skips PEND so the grant costs one enPhi1.
                    if (ack_act)     state_d = ARB_EXT;
                    else if (br_req) state_d = grant_ok ? ARB_GRANT : ARB_PEND;
                end
                ARB_PEND: begin
                    if (ack_act)       state_d = ARB_EXT;
                    else if (!br_req)  state_d = ARB_OWN;
                    else if (grant_ok) state_d = ARB_GRANT;
                end
                ARB_GRANT: begin
                    if (ack_act)      state_d = ARB_EXT;
                    else if (!br_req) state_d = ARB_RECLAIM;
                end
                ARB_EXT: begin
                    if (!ack_act) state_d = ARB_RECLAIM;
                end
                ARB_RECLAIM: begin
                    if (reclaim_q == '0) begin
                        state_d = (br_req && !ack_act) ? ARB_PEND : ARB_OWN;
                    end
                end
                default: state_d = ARB_OWN;
            endcase
        end
    end

    always_comb begin
        reclaim_d = reclaim_q;
        if (enPhi1 && state_d == ARB_RECLAIM && state_q != ARB_RECLAIM) begin
            reclaim_d = ARB_RECLAIM_W'(RECLAIM_PHI);
        end else if (enPhi2 && state_q == ARB_RECLAIM && reclaim_q != '0) begin
            reclaim_d = reclaim_q - ARB_RECLAIM_W'(1);
        end
    end

    assign bus_end_seen_d = enPhi2 ? busEnd : bus_end_seen_q;

    // Outputs are registered from the next state so they move on the same
    // edge as the state and never glitch on the pins.
    assign out_d = arb_outputs(state_d);

    always_ff @(posedge clk) begin
        if (extReset) begin
            state_q        <= ARB_OWN;
            reclaim_q      <= '0;
            bus_end_seen_q <= 1'b0;
            out_q          <= arb_outputs(ARB_OWN);
        end else begin
            state_q        <= state_d;
            reclaim_q      <= reclaim_d;
            bus_end_seen_q <= bus_end_seen_d;
            out_q          <= out_d;
        end
    end

    assign BGn        = out_q.bg_n;
    assign cpuOwnsBus = out_q.cpu_owns_bus;
    assign busIdle    = out_q.bus_idle;

endmodule

// File: tb/tb_fx68k_bus_arbiter.sv
// Directed bench for fx68k_bus_arbiter with SYNC_STAGES=2, RECLAIM_PHI=1.
// Outputs are checked as {BGn, cpuOwnsBus, busIdle} at the negedge after each phase.
module tb_fx68k_bus_arbiter;
    import fx68k_pkg::*;

    logic clk = 1'b0;
    logic extReset;
    logic enPhi1;
    logic enPhi2;
    logic BRn;
    logic BGACKn;
    logic busActive;
    logic busEnd;
    logic isRmc;
    logic BGn;
    logic cpuOwnsBus;
    logic busIdle;
    logic [2:0] outs;

    int n_cmp     = 0;
    int n_bad     = 0;
    int proto_err = 0;

    always #5 clk = ~clk;

    assign outs = {BGn, cpuOwnsBus, busIdle};

    fx68k_bus_arbiter #(
        .SYNC_STAGES (2),
        .RECLAIM_PHI (1)
    ) dut (
        .clk        (clk),
        .extReset   (extReset),
        .enPhi1     (enPhi1),
        .enPhi2     (enPhi2),
        .BRn        (BRn),
        .BGACKn     (BGACKn),
        .busActive  (busActive),
        .busEnd     (busEnd),
        .isRmc      (isRmc),
        .BGn        (BGn),
        .cpuOwnsBus (cpuOwnsBus),
        .busIdle    (busIdle)
    );

    // A core bus cycle while the CPU does not own the bus is a protocol error.
    always @(posedge clk) begin
        #1;
        if (busActive && !cpuOwnsBus && !extReset) proto_err++;
    end

    task automatic phi1();
        @(negedge clk); enPhi1 = 1'b1;
        @(negedge clk); enPhi1 = 1'b0;
    endtask

    task automatic phi2();
        @(negedge clk); enPhi2 = 1'b1;
        @(negedge clk); enPhi2 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        extReset  = 1'b1;
        enPhi1    = 1'b0;
        enPhi2    = 1'b0;
        BRn       = 1'b1;
        BGACKn    = 1'b1;
        busActive = 1'b0;
        busEnd    = 1'b0;
        isRmc     = 1'b0;
        repeat (2) @(negedge clk);
        extReset  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        extReset = 1'b1; BRn = 1'b0; BGACKn = 1'b0;
        phi2(); phi1(); phi2(); phi1();
        n_cmp++; if (outs !== 3'b110) begin n_bad++; $display("FAIL reset_held: outs=%b expected 110", outs); end
        n_cmp++; if (dut.state_q !== ARB_OWN) begin n_bad++; $display("FAIL reset_state: state=%0d expected %0d", dut.state_q, ARB_OWN); end
        BRn = 1'b1; BGACKn = 1'b1; extReset = 1'b0;
        phi2(); phi1();
        n_cmp++; if (outs !== 3'b110) begin n_bad++; $display("FAIL reset_release: outs=%b expected 110", outs); end
    endtask

    task automatic test_idle_grant();
        do_reset();
        BRn = 1'b0;
        phi2();
        n_cmp++; if (outs !== 3'b110) begin n_bad++; $display("FAIL idle_sync1: outs=%b expected 110", outs); end
        phi1();
        n_cmp++; if (outs !== 3'b110) begin n_bad++; $display("FAIL idle_phi1_early: outs=%b expected 110", outs); end
        phi2();
        n_cmp++; if (outs !== 3'b110) begin n_bad++; $display("FAIL idle_sync2: outs=%b expected 110", outs); end
        repeat (3) @(negedge clk);
        n_cmp++; if (outs !== 3'b110) begin n_bad++; $display("FAIL idle_no_enable: outs=%b expected 110", outs); end
        phi1();
        n_cmp++; if (outs !== 3'b000) begin n_bad++; $display("FAIL idle_grant: outs=%b expected 000", outs); end
    endtask

    task automatic test_read_cycle();
        do_reset();
        busActive = 1'b1; BRn = 1'b0;
        phi2(); phi1(); phi2(); phi1();
        n_cmp++; if (outs !== 3'b110) begin n_bad++; $display("FAIL read_pend: outs=%b expected 110", outs); end
        n_cmp++; if (dut.state_q !== ARB_PEND) begin n_bad++; $display("FAIL read_pend_state: state=%0d expected %0d", dut.state_q, ARB_PEND); end
        phi2(); phi1();
        n_cmp++; if (outs !== 3'b110) begin n_bad++; $display("FAIL read_hold: outs=%b expected 110", outs); end
        busEnd = 1'b1;
        phi2();
        busEnd = 1'b0; busActive = 1'b0;
        n_cmp++; if (outs !== 3'b110) begin n_bad++; $display("FAIL read_busend: outs=%b expected 110", outs); end
        phi1();
        n_cmp++; if (outs !== 3'b000) begin n_bad++; $display("FAIL read_grant: outs=%b expected 000", outs); end
    endtask

    task automatic test_tas();
        do_reset();
        isRmc = 1'b1; busActive = 1'b1; BRn = 1'b0;
        phi2(); phi1(); phi2(); phi1();
        n_cmp++; if (outs !== 3'b110) begin n_bad++; $display("FAIL tas_read: outs=%b expected 110", outs); end
        busEnd = 1'b1;
        phi2();
        busEnd = 1'b0; busActive = 1'b0;
        phi1();
        n_cmp++; if (outs !== 3'b110) begin n_bad++; $display("FAIL tas_gap: outs=%b expected 110", outs); end
        busActive = 1'b1;
        phi2(); phi1();
        n_cmp++; if (outs !== 3'b110) begin n_bad++; $display("FAIL tas_write: outs=%b expected 110", outs); end
        busEnd = 1'b1;
        phi2();
        busEnd = 1'b0; busActive = 1'b0;
        phi1();
        n_cmp++; if (outs !== 3'b110) begin n_bad++; $display("FAIL tas_locked: outs=%b expected 110", outs); end
        isRmc = 1'b0;
        phi2(); phi1();
        n_cmp++; if (outs !== 3'b000) begin n_bad++; $display("FAIL tas_grant: outs=%b expected 000", outs); end
    endtask

    task automatic test_handoff();
        do_reset();
        BRn = 1'b0;
        phi2(); phi1(); phi2(); phi1();
        n_cmp++; if (outs !== 3'b000) begin n_bad++; $display("FAIL hand_grant: outs=%b expected 000", outs); end
        BGACKn = 1'b0; BRn = 1'b1;
        phi2(); phi1();
        n_cmp++; if (outs !== 3'b000) begin n_bad++; $display("FAIL hand_sync: outs=%b expected 000", outs); end
        phi2(); phi1();
        n_cmp++; if (outs !== 3'b101) begin n_bad++; $display("FAIL hand_ext: outs=%b expected 101", outs); end
        n_cmp++; if (dut.state_q !== ARB_EXT) begin n_bad++; $display("FAIL hand_ack_priority: state=%0d expected %0d", dut.state_q, ARB_EXT); end
        phi2(); phi1();
        n_cmp++; if (outs !== 3'b101) begin n_bad++; $display("FAIL hand_hold: outs=%b expected 101", outs); end
        BGACKn = 1'b1;
        phi2(); phi1();
        n_cmp++; if (outs !== 3'b101) begin n_bad++; $display("FAIL hand_release_sync: outs=%b expected 101", outs); end
        phi2(); phi1();
        n_cmp++; if (dut.state_q !== ARB_RECLAIM) begin n_bad++; $display("FAIL hand_reclaim: state=%0d expected %0d", dut.state_q, ARB_RECLAIM); end
        phi2();
        n_cmp++; if (outs !== 3'b101) begin n_bad++; $display("FAIL hand_reclaim_count: outs=%b expected 101", outs); end
        phi1();
        n_cmp++; if (outs !== 3'b110) begin n_bad++; $display("FAIL hand_reclaimed: outs=%b expected 110", outs); end
    endtask

    task automatic test_abandoned();
        do_reset();
        BRn = 1'b0;
        phi2(); phi1(); phi2(); phi1();
        BRn = 1'b1;
        phi2(); phi1();
        n_cmp++; if (outs !== 3'b000) begin n_bad++; $display("FAIL aband_sync: outs=%b expected 000", outs); end
        phi2(); phi1();
        n_cmp++; if (outs !== 3'b101) begin n_bad++; $display("FAIL aband_reclaim: outs=%b expected 101", outs); end
        phi2(); phi1();
        n_cmp++; if (dut.state_q !== ARB_OWN || outs !== 3'b110) begin n_bad++; $display("FAIL aband_own: state=%0d outs=%b expected %0d/110", dut.state_q, outs, ARB_OWN); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        BGACKn = 1'b0;
        phi2(); phi1(); phi2(); phi1();
        n_cmp++; if (outs !== 3'b101) begin n_bad++; $display("FAIL rogue_ext: outs=%b expected 101", outs); end
        BRn = 1'b0; BGACKn = 1'b1;
        phi2(); phi1(); phi2(); phi1();
        n_cmp++; if (dut.state_q !== ARB_RECLAIM) begin n_bad++; $display("FAIL b2b_reclaim: state=%0d expected %0d", dut.state_q, ARB_RECLAIM); end
        phi2(); phi1();
        n_cmp++; if (dut.state_q !== ARB_PEND || outs !== 3'b110) begin n_bad++; $display("FAIL b2b_pend: state=%0d outs=%b expected %0d/110", dut.state_q, outs, ARB_PEND); end
        phi2(); phi1();
        n_cmp++; if (outs !== 3'b000) begin n_bad++; $display("FAIL b2b_grant: outs=%b expected 000", outs); end
    endtask

    task automatic test_reset_in_ext();
        do_reset();
        BGACKn = 1'b0;
        phi2(); phi1(); phi2(); phi1();
        n_cmp++; if (outs !== 3'b101) begin n_bad++; $display("FAIL rst_ext_pre: outs=%b expected 101", outs); end
        @(negedge clk); extReset = 1'b1;
        @(negedge clk);
        n_cmp++; if (outs !== 3'b110) begin n_bad++; $display("FAIL rst_ext_outs: outs=%b expected 110", outs); end
        n_cmp++; if (dut.state_q !== ARB_OWN) begin n_bad++; $display("FAIL rst_ext_state: state=%0d expected %0d", dut.state_q, ARB_OWN); end
        BGACKn = 1'b1; extReset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_grant();
        test_read_cycle();
        test_tas();
        test_handoff();
        test_abandoned();
        test_back_to_back();
        test_reset_in_ext();
        n_cmp++; if (proto_err != 0) begin n_bad++; $display("FAIL protocol: busActive without ownership seen %0d times, expected 0", proto_err); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fx68k_bus_arbiter.md
Name: fx68k_bus_arbiter

Overview:
Implements 68000 bus arbitration (BRn/BGn/BGACKn) for the fx68k core. Sits between the external arbitration pins and the core's bus-cycle sequencer. Decides when the CPU may start bus cycles and when ownership passes to an external master. Never breaks an active bus cycle or a read-modify-write (TAS) sequence.

Parameters:
SYNC_STAGES, 2, number of enPhi2-qualified synchronizer stages on BRn and BGACKn (1..3)
RECLAIM_PHI, 1, number of enPhi2 edges after BGACKn negation before the CPU regains the bus (1..7)

Ports:
clk  in  1  system clock
extReset  in  1  synchronous active-high reset
enPhi1  in  1  clock enable, next cycle is PHI1
enPhi2  in  1  clock enable, next cycle is PHI2
BRn  in  1  external bus request, active low, asynchronous
BGACKn  in  1  external bus grant acknowledge, active low, asynchronous
busActive  in  1  core bus cycle in progress (S0..S7)
busEnd  in  1  pulse on the enPhi2 ending the current bus cycle (S7)
isRmc  in  1  nano isRmc: locked read-modify-write sequence in progress
BGn  out  1  bus grant, active low
cpuOwnsBus  out  1  core may start a new bus cycle
busIdle  out  1  pins (AS/UDS/LDS/RW/address) must be tri-stated/idle

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, extReset). All state updates are qualified by enPhi1/enPhi2 as stated below; nothing changes on cycles with neither enable.
- Reset values: BGn=1, cpuOwnsBus=1, busIdle=0, state=OWN, synchronizers loaded with 1 (negated), reclaim counter=0. Reset mid-grant returns to OWN immediately; external master protection is not preserved across reset.
- Synchronizers: BRn and BGACKn are each shifted through SYNC_STAGES flops on enPhi2. brReq = !brSync, ackAct = !ackSync.
- States (updated on enPhi1 unless noted):
  OWN: CPU master. If brReq, go to PEND.
  PEND: If !brReq, go to OWN (request withdrawn). Else if !isRmc and (!busActive or busEnd seen in the previous enPhi2), go to GRANT.
  GRANT: BGn=0. If ackAct, go to EXT. Else if !brReq, go to RECLAIM (abandoned grant).
  EXT: BGn is negated (1) on the first enPhi1 in EXT. busIdle=1. Stay while ackAct. Go to RECLAIM when !ackAct.
  RECLAIM: busIdle=1. Counter loads RECLAIM_PHI on entry and decrements on enPhi2. Go to OWN when it reaches 0. If brReq is active at that point and ackAct is not, go to PEND instead (back-to-back master).
- cpuOwnsBus=1 only in OWN and in PEND while the current cycle has not ended. It drops on the same enPhi1 that enters GRANT. The core must not start a cycle while cpuOwnsBus=0.
- busActive asserted while cpuOwnsBus=0 is a protocol error. It is ignored by the arbiter; the bench flags it.
- Latency: with the bus idle, BRn falling to BGn low takes SYNC_STAGES enPhi2 edges plus 1 enPhi1 edge.
- isRmc held across a multi-cycle TAS blocks the grant until isRmc falls, even when busEnd pulses between its read and write cycles.
- ackAct seen while in OWN or PEND (rogue master): force EXT, set cpuOwnsBus=0, keep BGn=1.
- Simultaneous BRn negation and BGACKn assertion in GRANT: ackAct has priority, go to EXT.

Decomposition:
- In fx68k_pkg: typedef enum logic [2:0] e_arbState {ARB_OWN, ARB_PEND, ARB_GRANT, ARB_EXT, ARB_RECLAIM}; localparam ARB_SYNC_MAX = 3.
- One sub-module: fx68k_sync_ce, a parameterized enable-qualified reset-to-1 synchronizer, instantiated twice.

Test Plan:
- Idle bus, SYNC_STAGES=2, BRn low -> BGn low after 2 enPhi2 edges plus 1 enPhi1 edge; cpuOwnsBus=0 on that same edge.
- BRn low during a read at S2 -> BGn stays 1 until the enPhi1 after busEnd, then goes low; the cycle completes untouched.
- TAS: isRmc=1 over read+write with a busEnd between them, BRn low -> BGn low only after isRmc=0.
- Full handoff: BGn low, BGACKn low -> BGn high next enPhi1 and busIdle=1; BGACKn high -> cpuOwnsBus=1 after RECLAIM_PHI=1 enPhi2 edge plus sync delay.
- Abandoned grant: BRn high in GRANT with BGACKn never asserted -> BGn=1 and return to OWN via RECLAIM.
- extReset asserted in EXT -> next clk BGn=1, cpuOwnsBus=1, busIdle=0, state ARB_OWN.
